// File: rtl/prog_loader.sv
// Program loader: streams bytes from a valid/ready source into RAM over the MFA/MOC
// handshake, or reads the RAM back and compares it in verify mode.
module prog_loader #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LANES   = 1,
    parameter logic [7:0]  PAD     = 8'h00,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 Clk,
    input  logic                 Clear,
    input  logic                 Start,
    input  logic                 Mode,
    input  logic [ADDR_W-1:0]    Base,
    input  logic [ADDR_W:0]      Len,
    input  logic [7:0]           In_data,
    input  logic                 In_valid,
    output logic                 In_ready,
    output logic                 MFA,
    output logic                 RW,
    output logic [ADDR_W-1:0]    MAR,
    output logic [8*LANES-1:0]   MDR_out,
    input  logic [8*LANES-1:0]   MDR_in,
    input  logic                 MOC,
    output logic                 Busy,
    output logic                 Done,
    output logic [1:0]           Err,
    output logic [ADDR_W-1:0]    Err_addr,
    output logic [ADDR_W:0]      Count
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] LanesCnt = (ADDR_W + 1)'(LANES);
    localparam logic [LW-1:0]   LastLane = LW'(LANES - 1);
    localparam logic [TW-1:0]   LastWait = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StFill, StMem, StFin} state_e;

    state_e               state;
    logic                 mode_q;
    logic [ADDR_W:0]      len_q;
    logic [ADDR_W:0]      acc_q;
    logic [ADDR_W:0]      count_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [LW-1:0]        lane_cnt;
    logic [8*LANES-1:0]   lane_reg;
    logic [TW-1:0]        wait_cnt;
    logic [1:0]           err_q;
    logic [ADDR_W-1:0]    err_addr_q;
    logic                 done_q;

    logic [ADDR_W:0]      remaining;
    logic [ADDR_W:0]      valid_lanes;
    logic                 mm_found;
    logic [LW-1:0]        mm_lane;

    // Descending scan so the lowest mismatching lane (lowest address) wins.
    always_comb begin
        remaining   = len_q - count_q;
        valid_lanes = (remaining > LanesCnt) ? LanesCnt : remaining;
        mm_found    = 1'b0;
        mm_lane     = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (((ADDR_W + 1)'(i) < valid_lanes) &&
                (MDR_in[8*(int'(LANES)-1-i) +: 8] != lane_reg[8*(int'(LANES)-1-i) +: 8])) begin
                mm_found = 1'b1;
                mm_lane  = LW'(i);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clear) begin
            state      <= StIdle;
            mode_q     <= 1'b0;
            len_q      <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            lane_cnt   <= '0;
            lane_reg   <= '0;
            wait_cnt   <= '0;
            err_q      <= 2'b00;
            err_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (Start) begin
                        mode_q     <= Mode;
                        len_q      <= Len;
                        addr_q     <= Base;
                        acc_q      <= '0;
                        count_q    <= '0;
                        err_q      <= 2'b00;
                        err_addr_q <= '0;
                        lane_cnt   <= '0;
                        lane_reg   <= {LANES{PAD}};
                        state      <= (Len == '0) ? StFin : StFill;
                    end
                end
                StFill: begin
                    if (In_valid) begin
                        for (int i = 0; i < int'(LANES); i++) begin
                            if (lane_cnt == LW'(i)) lane_reg[8*(int'(LANES)-1-i) +: 8] <= In_data;
                        end
                        acc_q <= acc_q + 1'b1;
                        if (lane_cnt == LastLane || (acc_q + 1'b1) == len_q) begin
                            lane_cnt <= '0;
                            wait_cnt <= '0;
                            state    <= StMem;
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                StMem: begin
                    if (MOC) begin
                        if (mode_q && mm_found) begin
                            err_q      <= 2'b01;
                            err_addr_q <= addr_q + ADDR_W'(mm_lane);
                            state      <= StFin;
                        end else begin
                            count_q <= count_q + valid_lanes;
                            addr_q  <= addr_q + ADDR_W'(LANES);
                            if ((count_q + valid_lanes) < len_q) begin
                                lane_reg <= {LANES{PAD}};
                                state    <= StFill;
                            end else begin
                                state <= StFin;
                            end
                        end
                    end else if (wait_cnt == LastWait) begin
                        err_q      <= 2'b10;
                        err_addr_q <= addr_q;
                        state      <= StFin;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StFin: begin
                    done_q <= 1'b1;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign In_ready = (state == StFill);
    assign MFA      = (state == StMem);
    assign RW       = (state == StMem) ? mode_q : 1'b1;
    assign MAR      = addr_q;
    assign MDR_out  = lane_reg;
    assign Busy     = (state != StIdle);
    assign Done     = done_q;
    assign Err      = err_q;
    assign Err_addr = err_addr_q;
    assign Count    = count_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised program loader that streams a byte sequence into the datapath RAM over the MFA/MOC memory handshake, or reads it back and compares it in verify mode. It replaces simulation-only file preloading with a synthesizable loader that sits between a byte source (UART or host FIFO) and the RAM port, ahead of the CPU leaving reset. It generalises the load path in address width, transfer width and mode, and adds a stall timeout, mismatch reporting and partial-word padding.

## Interface
- ADDR_W, 9: RAM byte-address width; all addresses wrap modulo 2^ADDR_W.
- LANES, 1: bytes per memory transaction (1, 2 or 4), big-endian, first byte in the MSB lane.
- PAD, 8'h00: fill byte for unused lanes of a trailing partial word.
- TIMEOUT, 64: maximum cycles MFA may wait for MOC before aborting.
- Clk  in  1  rising-edge clock.
- Clear  in  1  synchronous reset, active-low, sampled on Clk.
- Start  in  1  single-cycle request; honoured only in IDLE.
- Mode  in  1  0 = load (write), 1 = verify (read and compare); latched at Start.
- Base  in  ADDR_W  first byte address; latched at Start.
- Len  in  ADDR_W+1  byte count, 0..2^ADDR_W; latched at Start.
- In_data  in  8  source byte.
- In_valid  in  1  source byte valid.
- In_ready  out  1  loader accepts a byte; a transfer occurs when In_valid and In_ready are both 1.
- MFA  out  1  memory function active (request).
- RW  out  1  1 = read, 0 = write.
- MAR  out  ADDR_W  transaction address.
- MDR_out  out  8*LANES  write data.
- MDR_in  in  8*LANES  read data, valid in the cycle MOC=1.
- MOC  in  1  memory operation complete.
- Busy  out  1  high outside IDLE.
- Done  out  1  one-cycle pulse at the end of an operation (normal end or abort).
- Err  out  2  00 ok, 01 verify mismatch, 10 timeout; sticky until the next Start or reset.
- Err_addr  out  ADDR_W  byte address of the first mismatch or timeout.
- Count  out  ADDR_W+1  bytes completed, i.e. written or compared.

## Operation
- States: IDLE, FILL, MEM, FIN.
- IDLE: on Start, latch Mode, Base and Len; clear Count, Err and the lane counter.
  - Len = 0: go to FIN.
  - Otherwise: go to FILL.
- FILL: In_ready = 1. Each accepted byte goes into the lane register at position lane_cnt (lane 0 = MSB). Count of accepted bytes increments.
  - When lane_cnt reaches LANES-1, or the byte accepted is the last of Len: go to MEM.
  - Lanes not written are set to PAD.
- MEM: MFA = 1. MAR = Base + word_index*LANES (mod 2^ADDR_W). RW = Mode. MDR_out = lane register. Wait for MOC.
  - On MOC = 1, verify mode: compare only the valid lanes of MDR_in against the lane register.
  - On mismatch: set Err = 01; Err_addr = address of the first differing byte (lowest lane); go to FIN.
  - On success: Count += valid lanes. If bytes remain, go to FILL; otherwise go to FIN.
- Timeout: a wait counter clears on entry to MEM. If MOC is still low after TIMEOUT cycles in MEM: Err = 10, Err_addr = MAR, go to FIN.
- FIN: Done = 1 for one cycle, then IDLE.
- Start while Busy is ignored.
- In_valid is ignored outside FILL.
- Clear low, in any state and mid-transfer: next state IDLE. All outputs drop to their reset values; any in-flight request is abandoned.

## Timing
- Reset values: In_ready 0, MFA 0, RW 1, MAR 0, MDR_out 0, Busy 0, Done 0, Err 00, Err_addr 0, Count 0.
- Start sampled at edge N: Busy = 1 and In_ready = 1 from cycle N+1.
- The last lane byte is accepted at edge K. In cycle K+1, MFA = 1 and In_ready = 0.
- MOC sampled high at edge M: MFA = 0 from cycle M+1. The next state (FILL or FIN) also starts in cycle M+1.
- MAR, MDR_out and RW are held stable for the whole time MFA = 1.
- No two requests are back to back: MFA always has at least one low cycle between transactions.
- Len = 0: Done pulses in cycle N+2; MFA is never asserted.
- Minimum load time, with MOC returned in the same cycle MFA rises: Len + ceil(Len/LANES) + 2 cycles from Start to Done.

## Test plan
- Load, LANES=1: Base=0, Len=4, bytes 8C,01,00,04 with MOC one cycle after MFA. Required: four writes at MAR 0..3 with RW=0; Done pulse; Count=4; Err=00.
- LANES=4, Len=6: Base=8, bytes 11..16. Required: first write MAR=8, MDR_out=11121314. Second write MAR=12, MDR_out=15160000. Count=6.
- Verify with one corrupted RAM byte: Mem[10]=FF, expected 13, LANES=4, Base=8. Required: Err=01, Err_addr=10, Done pulse, no further MFA.
- MOC held low, TIMEOUT=64. Required: Err=10 exactly 64 cycles after MFA rises; Err_addr=MAR; Done pulse; MFA=0 next cycle.
- Wrap and stall: ADDR_W=9, Base=510, Len=4, LANES=1, In_valid toggled every other cycle. Required: writes at 510, 511, 0, 1; In_ready only in FILL.
- Clear low mid-MEM, then Start again with Len=0. Required: all outputs return to reset values on the next edge; Done pulses at N+2 with no MFA.
